doodle_motion_ctrl: RTL and testbench
=====================================

# doodle_motion_ctrl

Per-frame vertical motion controller for the doodle. It sits directly downstream of the collision detector, consuming `hasCollide` and driving `doodleY` back into it. Motion is stepped one pixel at a time so the detector's exact-Y-equality test never skips a platform. When rising above the scroll line, the block converts upward motion into scroll pulses for the block-field stage.

## Interface
- `SCREEN_HEIGHT`, default 480: screen height in pixels; Y = 0 is the top and Y grows downward.
- `START_Y`, default 400: doodle Y after reset and after `start`.
- `SCROLL_LINE`, default 160: lowest Y the doodle may occupy while rising when scrolling is enabled.
- `JUMP_VELOCITY`, default 12: upward speed loaded on bounce and start, in pixels/frame.
- `GRAVITY`, default 1: velocity decrement per frame.
- `MAX_FALL`, default 12: maximum downward speed (saturation).
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; starts or restarts the game.
- `frameTick` in 1: one-cycle pulse, once per video frame.
- `hasCollide` in 1: combinational collision flag for the current `doodleY`.
- `doodleY` out 32: doodle vertical position.
- `velocity` out 8 signed: current speed; positive means upward.
- `scrollStep` out 1: one-cycle pulse; the field shifts down 1 px.
- `bounce` out 1: one-cycle pulse on landing.
- `gameOver` out 1: level signal; the doodle has left the screen bottom.
- `frameOverrun` out 1: sticky flag; a `frameTick` arrived while not in WAIT.

## Operation
- FSM states: IDLE, WAIT, STEP_UP, STEP_DN, CHECK, OVER.
- Reset values: `doodleY`=START_Y, `velocity`=0, all pulse outputs 0, `gameOver`=0, `frameOverrun`=0, state IDLE.
- IDLE or OVER, on `start`:
  - Load `doodleY`=START_Y and `velocity`=JUMP_VELOCITY.
  - Clear `gameOver` and `frameOverrun`.
  - Go to WAIT.
- WAIT, on `frameTick`:
  - Load `stepCnt`=|velocity|.
  - velocity>0: go to STEP_UP.
  - velocity<0: go to STEP_DN.
  - velocity=0: no movement; go directly to the gravity update.
- STEP_UP, one cycle per pixel:
  - If `doodleY` > SCROLL_LINE: decrement `doodleY`.
  - Otherwise: hold `doodleY` and pulse `scrollStep`.
  - Decrement `stepCnt`. When it reaches 0, apply gravity and go to WAIT.
- STEP_DN: increment `doodleY`, decrement `stepCnt`, go to CHECK.
- CHECK samples `hasCollide` at the new Y:
  - If 1: pulse `bounce`, set `velocity`=JUMP_VELOCITY, discard the remaining steps, go to WAIT. No gravity is applied that frame.
  - Else if `doodleY` ≥ SCREEN_HEIGHT-1: set `gameOver`=1, go to OVER.
  - Else if `stepCnt`=0: apply gravity, go to WAIT.
  - Else: go to STEP_DN.
- Collisions are ignored while rising; the doodle passes through platforms from below.
- Gravity update: `velocity` = max(velocity − GRAVITY, −MAX_FALL), computed in 9-bit signed arithmetic and then saturated.
- `frameTick` outside WAIT is dropped and sets `frameOverrun`.
- `frameTick` in IDLE or OVER is ignored and does not set `frameOverrun`.
- `start` outside IDLE/OVER is ignored.

## Timing
- `hasCollide` is combinational from the registered `doodleY`, so CHECK sees the Y written by the preceding STEP_DN cycle.
- Rising n px takes n cycles. Falling n px takes 2n cycles. Frame budget: 2·MAX_FALL+1 cycles ≪ the frame period.
- `scrollStep` and `bounce` are asserted only during the cycle in which they occur.
- `gameOver` is asserted from the cycle after the terminal CHECK until `start`.
- Asynchronous reset mid-step returns all state to reset values immediately. No partial step survives.

## Configuration
- `DOODLE_SCROLL_EN` defined: the scroll-line behaviour described above; `scrollStep` is active.
- `DOODLE_SCROLL_EN` undefined:
  - `scrollStep` is tied to 0.
  - STEP_UP decrements `doodleY` down to 0.
  - At Y=0 with steps remaining, velocity is forced to 0 and the FSM goes to WAIT (ceiling clamp).

## Structure
- Shared package `doodle_pkg`:
  - state enum `doodle_state_t`;
  - `velocity_t` (8-bit signed);
  - screen and physics constant defaults, shared with the collision detector and field stages.
- Single module with no sub-module. The FSM, step counter and saturating adder are small enough to live together.

## Test plan
- Reset, then `start`, then one `frameTick` with `hasCollide`=0 → `doodleY`=388, `velocity`=11, 12 cycles spent in STEP_UP.
- Velocity −3 from Y=200, `hasCollide` forced to 1 when Y=202 → `bounce` pulses once, `doodleY`=202, `velocity`=12, FSM in WAIT.
- Free fall until `velocity` reaches −12, then further frames → `velocity` stays −12 and never reaches −13.
- With `DOODLE_SCROLL_EN`: Y=165, velocity 12, one tick → `doodleY`=160, 7 `scrollStep` pulses. Without the macro → Y=153 and no `scrollStep` pulses.
- Falling with no platforms → `gameOver` rises at Y=479 and the FSM holds in OVER; `start` → Y=400, `gameOver`=0.
- `frameTick` injected during STEP_DN → `frameOverrun`=1, step sequence unaffected. `rst_n` low mid-STEP → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and screen/physics defaults for the doodle motion, collision and field stages.
package doodle_pkg;

  localparam int unsigned Y_W               = 32;
  localparam int unsigned VEL_W             = 8;

  localparam int unsigned SCREEN_HEIGHT_DEF = 480;
  localparam int unsigned START_Y_DEF       = 400;
  localparam int unsigned SCROLL_LINE_DEF   = 160;
  localparam int unsigned JUMP_VELOCITY_DEF = 12;
  localparam int unsigned GRAVITY_DEF       = 1;
  localparam int unsigned MAX_FALL_DEF      = 12;

  typedef logic signed [VEL_W-1:0] velocity_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    STEP_UP,
    STEP_DN,
    CHECK,
    OVER
  } doodle_state_t;

  // One gravity tick in 9-bit signed space, floored at -maxFall.
  function automatic velocity_t applyGravity(input velocity_t vel,
                                             input logic [VEL_W-1:0] grav,
                                             input logic [VEL_W-1:0] maxFall);
    logic signed [VEL_W:0] nextV;
    logic signed [VEL_W:0] floorV;
    nextV  = $signed({vel[VEL_W-1], vel}) - $signed({1'b0, grav});
    floorV = -$signed({1'b0, maxFall});
    return (nextV < floorV) ? velocity_t'(floorV[VEL_W-1:0]) : velocity_t'(nextV[VEL_W-1:0]);
  endfunction

endpackage

// File: rtl/doodle_motion_ctrl.sv
// Per-frame vertical motion of the doodle, stepped one pixel per cycle.
// Define DOODLE_SCROLL_EN to hold the doodle at the scroll line and emit scrollStep pulses.
module doodle_motion_ctrl
  import doodle_pkg::*;
#(
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned START_Y       = START_Y_DEF,
  parameter int unsigned JUMP_VELOCITY = JUMP_VELOCITY_DEF,
  parameter int unsigned GRAVITY       = GRAVITY_DEF,
  parameter int unsigned MAX_FALL      = MAX_FALL_DEF
`ifdef DOODLE_SCROLL_EN
  , parameter int unsigned SCROLL_LINE = SCROLL_LINE_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             frameTick,
  input  logic             hasCollide,
  output logic [Y_W-1:0]   doodleY,
  output velocity_t        velocity,
  output logic             scrollStep,
  output logic             bounce,
  output logic             gameOver,
  output logic             frameOverrun
);

  localparam logic [Y_W-1:0]   START_Y_V = Y_W'(START_Y);
  localparam logic [Y_W-1:0]   BOTTOM_Y  = Y_W'(SCREEN_HEIGHT - 1);
  localparam velocity_t        JUMP_V    = velocity_t'(JUMP_VELOCITY);
  localparam logic [VEL_W-1:0] GRAV_V    = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0] MAXF_V    = VEL_W'(MAX_FALL);
`ifdef DOODLE_SCROLL_EN
  localparam logic [Y_W-1:0]   SCROLL_Y  = Y_W'(SCROLL_LINE);
`endif

  doodle_state_t    state;
  logic [VEL_W-1:0] stepCnt;
  logic [VEL_W-1:0] absVel;
  velocity_t        gravVel;
  logic             busy;

  assign gravVel = applyGravity(velocity, GRAV_V, MAXF_V);
  assign absVel  = velocity[VEL_W-1] ? $unsigned(-velocity) : $unsigned(velocity);
  assign busy    = (state == STEP_UP) || (state == STEP_DN) || (state == CHECK);

`ifndef DOODLE_SCROLL_EN
  assign scrollStep = 1'b0;
`endif

  // Motion FSM: one pixel per cycle rising, step+check pair per pixel falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      doodleY      <= START_Y_V;
      velocity     <= '0;
      stepCnt      <= '0;
      bounce       <= 1'b0;
      gameOver     <= 1'b0;
      frameOverrun <= 1'b0;
`ifdef DOODLE_SCROLL_EN
      scrollStep   <= 1'b0;
`endif
    end else begin
      bounce <= 1'b0;
`ifdef DOODLE_SCROLL_EN
      scrollStep <= 1'b0;
`endif
      if (frameTick && busy) frameOverrun <= 1'b1;

      unique case (state)
        IDLE, OVER: begin
          if (start) begin
            doodleY      <= START_Y_V;
            velocity     <= JUMP_V;
            gameOver     <= 1'b0;
            frameOverrun <= 1'b0;
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (frameTick) begin
            stepCnt <= absVel;
            if (velocity[VEL_W-1])        state    <= STEP_DN;
            else if (velocity != '0)      state    <= STEP_UP;
            else                          velocity <= gravVel;
          end
        end

        STEP_UP: begin
`ifdef DOODLE_SCROLL_EN
          if (doodleY > SCROLL_Y) doodleY    <= doodleY - Y_W'(1);
          else                    scrollStep <= 1'b1;
          stepCnt <= stepCnt - VEL_W'(1);
          if (stepCnt == VEL_W'(1)) begin
            velocity <= gravVel;
            state    <= WAIT;
          end
`else
          // Ceiling clamp: motion stops dead at the top row.
          if (doodleY == '0) begin
            velocity <= '0;
            state    <= WAIT;
          end else begin
            doodleY <= doodleY - Y_W'(1);
            stepCnt <= stepCnt - VEL_W'(1);
            if (stepCnt == VEL_W'(1)) begin
              velocity <= gravVel;
              state    <= WAIT;
            end
          end
`endif
        end

        STEP_DN: begin
          doodleY <= doodleY + Y_W'(1);
          stepCnt <= stepCnt - VEL_W'(1);
          state   <= CHECK;
        end

        // hasCollide here reflects the Y written by the preceding STEP_DN.
        CHECK: begin
          if (hasCollide) begin
            bounce   <= 1'b1;
            velocity <= JUMP_V;
            stepCnt  <= '0;
            state    <= WAIT;
          end else if (doodleY >= BOTTOM_Y) begin
            gameOver <= 1'b1;
            state    <= OVER;
          end else if (stepCnt == '0) begin
            velocity <= gravVel;
            state    <= WAIT;
          end else begin
            state <= STEP_DN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Randomized bench for doodle_motion_ctrl against a frame-level physics model.
module tb_doodle_motion_ctrl;

  localparam int START  = 400;
  localparam int JUMP   = 12;
  localparam int MAXF   = 12;
  localparam int BOTTOM = 479;
  localparam int SCROLL = 160;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              frameTick = 1'b0;
  logic              hasCollide;
  logic [31:0]       doodleY;
  logic signed [7:0] velocity;
  logic              scrollStep, bounce, gameOver, frameOverrun;

  bit platMap [0:511];
  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  typedef struct { int y; int v; bit sc; bit bn; bit ov; } snap_t;
  typedef enum { M_IDLE, M_WAIT, M_OVER } mode_t;

  snap_t q[$];
  mode_t mode = M_IDLE;
  int    eY = START;
  int    eV = 0;
  bit    eSc = 1'b0, eBn = 1'b0, eOver = 1'b0, eOverrun = 1'b0;

  always #5 clk = ~clk;

  assign hasCollide = platMap[doodleY[8:0]];

  doodle_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frameTick(frameTick),
    .hasCollide(hasCollide), .doodleY(doodleY), .velocity(velocity),
    .scrollStep(scrollStep), .bounce(bounce), .gameOver(gameOver),
    .frameOverrun(frameOverrun)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      chk("doodleY", doodleY, eY);
      chk("velocity", velocity, eV);
      chk("scrollStep", scrollStep, eSc);
      chk("bounce", bounce, eBn);
      chk("gameOver", gameOver, eOver);
      chk("frameOverrun", frameOverrun, eOverrun);
    end
  end

  function automatic int grav(input int v);
    return (v - 1 < -MAXF) ? -MAXF : v - 1;
  endfunction

  // Expand one frame into the per-cycle outputs that follow the tick.
  task automatic buildFrame();
    int y;
    int v;
    snap_t s;
    y = eY;
    v = eV;
    if (eV > 0) begin
      for (int j = 1; j <= eV; j++) begin
        s = '{y: y, v: v, sc: 1'b0, bn: 1'b0, ov: 1'b0};
`ifdef DOODLE_SCROLL_EN
        if (y > SCROLL) y--;
        else s.sc = 1'b1;
`else
        if (y == 0) begin
          s.v = 0;
          q.push_back(s);
          return;
        end
        y--;
`endif
        if (j == eV) v = grav(v);
        s.y = y;
        s.v = v;
        q.push_back(s);
      end
    end else begin
      for (int j = 1; j <= -eV; j++) begin
        y++;
        s = '{y: y, v: v, sc: 1'b0, bn: 1'b0, ov: 1'b0};
        q.push_back(s);
        if (platMap[y]) begin
          s.v  = JUMP;
          s.bn = 1'b1;
          q.push_back(s);
          return;
        end
        if (y >= BOTTOM) begin
          s.ov = 1'b1;
          q.push_back(s);
          return;
        end
        if (j == -eV) v = grav(v);
        s.v = v;
        q.push_back(s);
      end
    end
  endtask

  task automatic modelAdvance(input bit tick, input bit st);
    snap_t s;
    eSc = 1'b0;
    eBn = 1'b0;
    if (q.size() > 0) begin
      s = q.pop_front();
      eY  = s.y;
      eV  = s.v;
      eSc = s.sc;
      eBn = s.bn;
      if (s.ov) begin
        eOver = 1'b1;
        mode  = M_OVER;
      end
      if (tick) eOverrun = 1'b1;
    end else if (mode == M_WAIT) begin
      if (tick) begin
        if (eV == 0) eV = grav(eV);
        else buildFrame();
      end
    end else if (st) begin
      eY = START;
      eV = JUMP;
      eOver = 1'b0;
      eOverrun = 1'b0;
      mode = M_WAIT;
    end
  endtask

  task automatic step(input bit tick, input bit st);
    frameTick = tick;
    start = st;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    start = 1'b0;
    modelAdvance(tick, st);
  endtask

  task automatic runFrame(input int injectAt);
    step(1'b1, 1'b0);
    for (int j = 0; j < 200 && q.size() > 0; j++) step(j == injectAt, 1'b0);
  endtask

  task automatic doReset();
    #1 rst_n = 1'b0;
    q.delete();
    eY = START; eV = 0; eSc = 1'b0; eBn = 1'b0; eOver = 1'b0; eOverrun = 1'b0;
    mode = M_IDLE;
    #1;
    chk("rst doodleY", doodleY, 400);
    chk("rst velocity", velocity, 0);
    chk("rst scrollStep", scrollStep, 0);
    chk("rst bounce", bounce, 0);
    chk("rst gameOver", gameOver, 0);
    chk("rst frameOverrun", frameOverrun, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    foreach (platMap[i]) platMap[i] = 1'b0;
    #2 rst_n = 1'b0;
    #1 cmpEn = 1'b1;
    chk("init doodleY", doodleY, 400);
    chk("init velocity", velocity, 0);
    chk("init gameOver", gameOver, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed pins: first jump, saturation, overrun, bottom-out and restart.
    step(1'b1, 1'b0);
    chk("idle tick overrun", frameOverrun, 0);
    step(1'b0, 1'b1);
    chk("start velocity", velocity, 12);
    runFrame(-1);
    chk("jump doodleY", doodleY, 388);
    chk("jump velocity", velocity, 11);
    for (int k = 0; k < 40 && eV != -12; k++) runFrame(-1);
    chk("sat velocity", velocity, -12);
    chk("sat doodleY", doodleY, 388);
    runFrame(2);
    chk("sat hold velocity", velocity, -12);
    chk("fall doodleY", doodleY, 400);
    chk("overrun flag", frameOverrun, 1);
    for (int k = 0; k < 20 && mode != M_OVER; k++) runFrame(-1);
    chk("over flag", gameOver, 1);
    chk("over doodleY", doodleY, 479);
    repeat (3) step(1'b1, 1'b0);
    chk("over hold", gameOver, 1);
    step(1'b0, 1'b1);
    chk("restart doodleY", doodleY, 400);
    chk("restart gameOver", gameOver, 0);
    chk("restart overrun", frameOverrun, 0);

    // Random games: empty fields fall out, dense fields climb to the top.
    for (int g = 0; g < 10; g++) begin
      int dens;
      dens = (g % 3 == 0) ? 0 : int'($urandom_range(6, 14));
      foreach (platMap[i]) platMap[i] = (dens != 0) && ($urandom_range(1, dens) == 1);
      if (mode == M_WAIT) doReset();
      step(1'b0, 1'b1);
      for (int c = 0; c < 1500 && mode != M_OVER; c++) begin
        if (q.size() > 0) step($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
        else              step($urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      end
      if (mode != M_OVER) begin
        for (int c = 0; c < 100 && q.size() == 0; c++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        doReset();
      end
    end

    step(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
